audio_mixer_v2: RTL and testbench



---
 rtl/audio_mixer_v2_if.sv | 13 +
 rtl/audio_mixer_v2.sv | 166 ++++++++++++++++
 tb/tb_audio_mixer_v2.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_v2_if.sv
// CPU memory-mapped register bus for the audio mixer: single-cycle ready ack
// one cycle after valid, registered read data.
interface audio_mixer_v2_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/audio_mixer_v2.sv
// N-channel serial audio mixer: snapshot on tick, one gain/mute-weighted channel
// per cycle, master right-shift, saturate to OUT_W, one-cycle out_valid strobe.
module audio_mixer_v2 #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  audio_mixer_v2_if.slave        bus,
  input  logic                   sample_tick,
  input  logic [N_CH*IN_W-1:0]   ch_in,
  output logic [OUT_W-1:0]       out,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int unsigned ACC_W  = IN_W + 4 + $clog2(N_CH);
  localparam int unsigned PROD_W = IN_W + 4;
  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [4:0] A_CTRL   = 5'd16;
  localparam logic [4:0] A_STATUS = 5'd17;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IN_W-1:0]   snap_q [N_CH];
  logic [IN_W-1:0]   snap_d [N_CH];
  logic [3:0]        gain_q [N_CH];
  logic [3:0]        gain_d [N_CH];
  logic [N_CH-1:0]   mute_q, mute_d;
  logic [3:0]        shift_q, shift_d;
  logic              clip_q, clip_d;
  logic              overrun_q, overrun_d;
  logic [OUT_W-1:0]  out_d;
  logic              out_valid_d;
  logic              busy_d;

  logic              bus_req_c;
  logic              bus_wr_c;
  logic [4:0]        word_c;
  logic [31:0]       rd_c;
  logic [PROD_W-1:0] prod_c;
  logic [EXT_W-1:0]  shifted_c;
  logic              bus_unused_c;

  assign bus_req_c    = bus.valid & ~bus.ready;
  assign bus_wr_c     = bus_req_c & bus.wstrb[0];
  assign word_c       = bus.addr[6:2];
  assign bus_unused_c = ^{bus.addr, bus.wstrb, bus.wdata};

  // Register read mux; unmapped words and absent channels read as zero
  always_comb begin
    rd_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (word_c == 5'(k)) rd_c = {28'd0, gain_q[k]};
    end
    if (word_c == A_CTRL)   rd_c = {16'(mute_q), 12'd0, shift_q};
    if (word_c == A_STATUS) rd_c = {29'd0, overrun_q, clip_q, busy};
  end

  // Next-state: register writes, mix sequencing, sticky status
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    snap_d      = snap_q;
    gain_d      = gain_q;
    mute_d      = mute_q;
    shift_d     = shift_q;
    clip_d      = clip_q;
    overrun_d   = overrun_q;
    out_d       = out;
    out_valid_d = 1'b0;
    prod_c      = mute_q[idx_q] ? '0
                : PROD_W'(snap_q[idx_q]) * PROD_W'(gain_q[idx_q]);
    shifted_c   = EXT_W'(acc_q) >> shift_q;

    if (bus_wr_c) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (word_c == 5'(k)) gain_d[k] = bus.wdata[3:0];
      end
      if (word_c == A_CTRL) begin
        shift_d = bus.wdata[3:0];
        mute_d  = bus.wdata[16 +: N_CH];
      end
      if (word_c == A_STATUS) begin
        if (bus.wdata[1]) clip_d    = 1'b0;
        if (bus.wdata[2]) overrun_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          for (int k = 0; k < int'(N_CH); k++) snap_d[k] = ch_in[k*IN_W +: IN_W];
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        if (idx_q == IDX_W'(N_CH - 1)) state_d = S_OUT;
        else                           idx_d   = idx_q + IDX_W'(1);
      end
      S_OUT: begin
        if (|(shifted_c >> OUT_W)) begin
          out_d  = '1;
          clip_d = 1'b1;
        end else begin
          out_d  = shifted_c[OUT_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A set in the same cycle as a W1C clear must win
    if (sample_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      snap_q    <= '{default: '0};
      gain_q    <= '{default: '0};
      mute_q    <= '0;
      shift_q   <= '0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      snap_q    <= snap_d;
      gain_q    <= gain_d;
      mute_q    <= mute_d;
      shift_q   <= shift_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      bus.ready <= bus_req_c;
      if (bus_req_c) bus.rdata <= rd_c;
    end
  end

endmodule

// File: tb/tb_audio_mixer_v2.sv
// Directed bench for audio_mixer_v2: bus register access plus a scoreboard of
// expected mix results popped on each out_valid strobe.
module tb_audio_mixer_v2;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 12;

  logic clk = 1'b0;
  logic resetn;
  logic sample_tick;
  logic [N_CH*IN_W-1:0] ch_in;
  logic [OUT_W-1:0] out;
  logic out_valid;
  logic busy;

  audio_mixer_v2_if bus();

  audio_mixer_v2 #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .sample_tick(sample_tick),
    .ch_in(ch_in), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ov_count = 0;
  logic [OUT_W-1:0] exp_q[$];

  int unsigned m_gain [N_CH];
  int unsigned m_ch   [N_CH];
  logic [15:0] m_mute;
  int unsigned m_shift;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid cycle must match the oldest pending mix
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_count++;
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_out", 32'(out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] model_mix();
    int unsigned acc = 0;
    for (int k = 0; k < int'(N_CH); k++)
      if (!m_mute[k]) acc += m_ch[k] * m_gain[k];
    acc = acc >> m_shift;
    return (acc > 32'd4095) ? {OUT_W{1'b1}} : OUT_W'(acc);
  endfunction

  task automatic drive_ch();
    for (int k = 0; k < int'(N_CH); k++) ch_in[k*IN_W +: IN_W] = IN_W'(m_ch[k]);
  endtask

  task automatic bus_write(input logic [4:0] word, input logic [31:0] data);
    bus.valid = 1'b1;
    bus.wstrb = 4'hF;
    bus.addr  = {25'd0, word, 2'b00};
    bus.wdata = data;
    tick_clk();
    check("wr_ready", 32'(bus.ready), 32'd1);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    tick_clk();
    check("wr_ready_drop", 32'(bus.ready), 32'd0);
    if (word < 5'(N_CH)) m_gain[word] = 32'(data[3:0]);
    if (word == 5'd16) begin
      m_shift = 32'(data[3:0]);
      m_mute  = data[31:16];
    end
  endtask

  task automatic bus_read(input logic [4:0] word, output logic [31:0] data);
    bus.valid = 1'b1;
    bus.wstrb = 4'h0;
    bus.addr  = {25'd0, word, 2'b00};
    tick_clk();
    check("rd_ready", 32'(bus.ready), 32'd1);
    data = bus.rdata;
    bus.valid = 1'b0;
    tick_clk();
    check("rd_ready_drop", 32'(bus.ready), 32'd0);
  endtask

  task automatic wait_out(input int budget);
    int start = ov_count;
    for (int i = 0; i < budget && ov_count == start; i++) tick_clk();
    check("mix_done", 32'(ov_count - start), 32'd1);
  endtask

  task automatic run_mix(output logic [OUT_W-1:0] e);
    e = model_mix();
    exp_q.push_back(e);
    drive_ch();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    wait_out(20);
    check("mix_out_held", 32'(out), 32'(e));
  endtask

  logic [31:0] rd;
  logic [OUT_W-1:0] e;
  int base;

  initial begin
    bus.valid = 1'b0; bus.wstrb = '0; bus.addr = '0; bus.wdata = '0;
    sample_tick = 1'b0; ch_in = '0; resetn = 1'b0;
    m_mute = '0; m_shift = 0;
    for (int k = 0; k < int'(N_CH); k++) begin m_gain[k] = 0; m_ch[k] = 0; end

    // 1: reset state and basic register access
    repeat (3) tick_clk();
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    resetn = 1'b1;
    tick_clk();
    bus_read(5'd0, rd);  check("gain0_rst", rd, 32'd0);
    bus_read(5'd16, rd); check("ctrl_rst", rd, 32'd0);
    bus_read(5'd17, rd); check("status_rst", rd, 32'd0);
    bus_write(5'd10, 32'd7);  bus_read(5'd10, rd); check("gain10_absent", rd, 32'd0);
    bus_write(5'd20, 32'hFFFF_FFFF); bus_read(5'd20, rd); check("word20_zero", rd, 32'd0);
    bus_write(5'd1, 32'hFFFF_FFF5); bus_read(5'd1, rd); check("gain1_4bit", rd, 32'd5);
    bus_write(5'd1, 32'd0);

    // 2: single channel, exact latency and busy window
    bus_write(5'd0, 32'd1);
    m_ch[0] = 32'h80;
    exp_q.push_back(model_mix());
    drive_ch();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    for (int c = 0; c < 9; c++) begin
      check("busy_window", 32'(busy), 32'd1);
      check("no_early_valid", 32'(out_valid), 32'd0);
      tick_clk();
    end
    check("valid_at_edge9", 32'(out_valid), 32'd1);
    check("out_080", 32'(out), 32'h080);
    check("busy_drop", 32'(busy), 32'd0);
    tick_clk();
    check("valid_one_cycle", 32'(out_valid), 32'd0);

    // 3: saturation, clip sticky W1C, shift
    for (int k = 0; k < int'(N_CH); k++) begin
      bus_write(5'(k), 32'd15);
      m_ch[k] = 32'hFF;
    end
    run_mix(e);
    check("sat_fff", 32'(out), 32'hFFF);
    bus_read(5'd17, rd); check("status_clip", rd, 32'h2);
    bus_write(5'd17, 32'h2);
    bus_read(5'd17, rd); check("clip_cleared", rd, 32'h0);
    bus_write(5'd16, 32'd3);
    run_mix(e);
    check("shift3_ef1", 32'(out), 32'hEF1);
    bus_read(5'd17, rd); check("no_clip_shift", rd, 32'h0);

    // 4: linear gains with mute
    for (int k = 0; k < int'(N_CH); k++) begin
      bus_write(5'(k), 32'd0);
      m_ch[k] = 32'hFF;
    end
    bus_write(5'd0, 32'd4); m_ch[0] = 10;
    bus_write(5'd1, 32'd2); m_ch[1] = 3;
    bus_write(5'd16, 32'h0001_0000);
    bus_read(5'd16, rd); check("ctrl_mute_rd", rd, 32'h0001_0000);
    run_mix(e);
    check("mute_6", 32'(out), 32'd6);
    bus_write(5'd16, 32'd0);
    run_mix(e);
    check("unmute_46", 32'(out), 32'd46);

    // 5: overrun tick ignored, snapshot isolates ch_in changes
    base = ov_count;
    exp_q.push_back(model_mix());
    drive_ch();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    ch_in = '1;
    tick_clk();
    tick_clk();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    repeat (14) tick_clk();
    check("overrun_single_valid", 32'(ov_count - base), 32'd1);
    check("overrun_first_mix", 32'(out), 32'd46);
    bus_read(5'd17, rd); check("status_overrun", rd, 32'h4);
    bus_write(5'd17, 32'h4);
    bus_read(5'd17, rd); check("overrun_cleared", rd, 32'h0);

    // 6: reset during accumulation discards the mix
    drive_ch();
    sample_tick = 1'b1;
    tick_clk();
    sample_tick = 1'b0;
    repeat (4) tick_clk();
    check("busy_mid_acc", 32'(busy), 32'd1);
    resetn = 1'b0;
    tick_clk();
    resetn = 1'b1;
    m_mute = '0; m_shift = 0;
    for (int k = 0; k < int'(N_CH); k++) m_gain[k] = 0;
    check("rst_acc_out", 32'(out), 32'd0);
    check("rst_acc_busy", 32'(busy), 32'd0);
    base = ov_count;
    repeat (12) tick_clk();
    check("rst_acc_no_valid", 32'(ov_count - base), 32'd0);
    bus_read(5'd0, rd); check("gain0_after_rst", rd, 32'd0);
    bus_write(5'd0, 32'd4);
    bus_write(5'd1, 32'd2);
    run_mix(e);
    check("post_rst_46", 32'(out), 32'd46);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
